// File: rtl/spi_slave_rx.sv
//------------------------------------------------------------------------------
// Module  : spi_slave_rx
// Brief   : SPI mode-0 slave receiver; oversampled, MSB-first, frames bytes into words.
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module spi_slave_rx #(
    parameter int SYNC_STAGES     = 2,
    parameter int BYTES_PER_FRAME = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sclk,
    input  logic                         mosi,
    input  logic                         ss_n,
    output logic                         miso,
    input  logic [7:0]                   tx_status,
    output logic [7:0]                   rx_byte,
    output logic                         rx_byte_valid,
    output logic [8*BYTES_PER_FRAME-1:0] rx_word,
    output logic                         rx_word_valid,
    output logic                         frame_err,
    output logic                         busy
);

    localparam int W           = 8 * BYTES_PER_FRAME;
    localparam int BCW         = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
    localparam int INIT_CYCLES = SYNC_STAGES + 1;
    localparam int ICW         = $clog2(INIT_CYCLES + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_FRAME - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_hist_q, sclk_hist_d;
    logic                   ss_hist_q, ss_hist_d;
    logic [ICW-1:0]         init_cnt_q, init_cnt_d;
    logic                   armed_q, armed_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [6:0]             rx_shift_q, rx_shift_d;
    logic [W-1:0]           word_shift_q, word_shift_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic                   tx_skip_q, tx_skip_d;
    logic [7:0]             rx_byte_q, rx_byte_d;
    logic [W-1:0]           rx_word_q, rx_word_d;
    logic                   rx_byte_valid_q, rx_byte_valid_d;
    logic                   rx_word_valid_q, rx_word_valid_d;
    logic                   frame_err_q, frame_err_d;

    logic       sclk_s, ss_s, mosi_s;
    logic       s_rise, s_fall, sel_fall, sel_rise;
    logic       init_done;
    logic [7:0] byte_next;
    logic [W-1:0] word_next;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign s_rise    = sclk_s & ~sclk_hist_q;
    assign s_fall    = ~sclk_s & sclk_hist_q;
    assign sel_fall  = ~ss_s & ss_hist_q;
    assign sel_rise  = ss_s & ~ss_hist_q;
    assign init_done = (init_cnt_q == ICW'(INIT_CYCLES));
    assign byte_next = {rx_shift_q, mosi_s};
    assign word_next = W'({word_shift_q, byte_next});

    always_comb begin
        state_d         = state_q;
        sclk_sync_d     = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        ss_sync_d       = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
        mosi_sync_d     = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_hist_d     = sclk_s;
        ss_hist_d       = ss_s;
        init_cnt_d      = init_done ? init_cnt_q : init_cnt_q + 1'b1;
        // A frame may only open once ss_n has been seen high with real samples,
        // so a select already low at reset release is not taken as a new frame.
        armed_d         = armed_q | (init_done & ss_s);
        bit_cnt_d       = bit_cnt_q;
        byte_cnt_d      = byte_cnt_q;
        rx_shift_d      = rx_shift_q;
        word_shift_d    = word_shift_q;
        tx_shift_d      = tx_shift_q;
        tx_skip_d       = tx_skip_q;
        rx_byte_d       = rx_byte_q;
        rx_word_d       = rx_word_q;
        rx_byte_valid_d = 1'b0;
        rx_word_valid_d = 1'b0;
        frame_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_fall && armed_q) begin
                    state_d    = RECV;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    tx_shift_d = tx_status;
                    tx_skip_d  = 1'b0;
                end
            end
            RECV: begin
                if (s_rise) begin
                    rx_shift_d = byte_next[6:0];
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_byte_d       = byte_next;
                        rx_byte_valid_d = 1'b1;
                        word_shift_d    = word_next;
                        tx_shift_d      = tx_status;
                        tx_skip_d       = 1'b1;
                        if (byte_cnt_q == LAST_BYTE) begin
                            byte_cnt_d      = '0;
                            rx_word_d       = word_next;
                            rx_word_valid_d = 1'b1;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end
                end else if (s_fall) begin
                    // The fall right after a byte-boundary reload must keep bit 7.
                    if (tx_skip_q) begin
                        tx_skip_d = 1'b0;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
                if (sel_rise) begin
                    state_d     = IDLE;
                    frame_err_d = (bit_cnt_d != 3'd0) || (byte_cnt_d != '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            sclk_sync_q     <= '0;
            ss_sync_q       <= '1;
            mosi_sync_q     <= '0;
            sclk_hist_q     <= 1'b0;
            ss_hist_q       <= 1'b1;
            init_cnt_q      <= '0;
            armed_q         <= 1'b0;
            bit_cnt_q       <= '0;
            byte_cnt_q      <= '0;
            rx_shift_q      <= '0;
            word_shift_q    <= '0;
            tx_shift_q      <= '0;
            tx_skip_q       <= 1'b0;
            rx_byte_q       <= '0;
            rx_word_q       <= '0;
            rx_byte_valid_q <= 1'b0;
            rx_word_valid_q <= 1'b0;
            frame_err_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            sclk_sync_q     <= sclk_sync_d;
            ss_sync_q       <= ss_sync_d;
            mosi_sync_q     <= mosi_sync_d;
            sclk_hist_q     <= sclk_hist_d;
            ss_hist_q       <= ss_hist_d;
            init_cnt_q      <= init_cnt_d;
            armed_q         <= armed_d;
            bit_cnt_q       <= bit_cnt_d;
            byte_cnt_q      <= byte_cnt_d;
            rx_shift_q      <= rx_shift_d;
            word_shift_q    <= word_shift_d;
            tx_shift_q      <= tx_shift_d;
            tx_skip_q       <= tx_skip_d;
            rx_byte_q       <= rx_byte_d;
            rx_word_q       <= rx_word_d;
            rx_byte_valid_q <= rx_byte_valid_d;
            rx_word_valid_q <= rx_word_valid_d;
            frame_err_q     <= frame_err_d;
        end
    end

    assign miso          = (state_q == RECV) ? tx_shift_q[7] : 1'b0;
    assign busy          = (state_q == RECV);
    assign rx_byte       = rx_byte_q;
    assign rx_word       = rx_word_q;
    assign rx_byte_valid = rx_byte_valid_q;
    assign rx_word_valid = rx_word_valid_q;
    assign frame_err     = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
//------------------------------------------------------------------------------
// Module  : tb_spi_slave_rx
// Brief   : Directed self-checking bench for spi_slave_rx (2-byte frames).
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_spi_slave_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        ss_n = 1'b1;
    logic [7:0]  tx_status = 8'h00;
    logic        miso;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic [15:0] rx_word;
    logic        rx_word_valid;
    logic        frame_err;
    logic        busy;

    spi_slave_rx #(.SYNC_STAGES(2), .BYTES_PER_FRAME(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .sclk          (sclk),
        .mosi          (mosi),
        .ss_n          (ss_n),
        .miso          (miso),
        .tx_status     (tx_status),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .rx_word       (rx_word),
        .rx_word_valid (rx_word_valid),
        .frame_err     (frame_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  byte_q[$];
    logic [15:0] word_q[$];
    int          ferr_cnt = 0;
    int          pulse_err = 0;
    logic        prev_bv = 1'b0, prev_wv = 1'b0, prev_fe = 1'b0;
    logic [7:0]  frame_data[5];
    logic [7:0]  miso_seen[4];

    // Event recorder: collects pulses and flags pulses longer than one clk
    // or a word pulse without its coinciding byte pulse.
    always @(negedge clk) begin
        if (rx_byte_valid) byte_q.push_back(rx_byte);
        if (rx_word_valid) begin
            word_q.push_back(rx_word);
            if (!rx_byte_valid) pulse_err++;
        end
        if (frame_err) ferr_cnt++;
        if ((rx_byte_valid && prev_bv) || (rx_word_valid && prev_wv) || (frame_err && prev_fe))
            pulse_err++;
        prev_bv = rx_byte_valid;
        prev_wv = rx_word_valid;
        prev_fe = frame_err;
    end

    task automatic clear_mon();
        byte_q.delete();
        word_q.delete();
        ferr_cnt  = 0;
        pulse_err = 0;
    endtask

    task automatic sclk_bit(input logic b, output logic m);
        mosi = b;
        repeat (8) @(negedge clk);
        m = miso;
        sclk = 1'b1;
        repeat (8) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input int nbytes, input int extra_bits);
        logic [7:0] mb;
        logic       m;
        mb = 8'h00;
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int k = 0; k < nbytes; k++) begin
            for (int i = 7; i >= 0; i--) begin
                sclk_bit(frame_data[k][i], m);
                mb[i] = m;
            end
            miso_seen[k] = mb;
        end
        for (int i = 0; i < extra_bits; i++) sclk_bit(frame_data[nbytes][7-i], m);
        repeat (8) @(negedge clk);
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({rx_byte, rx_word, rx_byte_valid, rx_word_valid, frame_err, busy, miso} !== 29'h0) begin
            errors++;
            $display("FAIL reset_outputs: got byte=%h word=%h bv=%b wv=%b fe=%b busy=%b miso=%b, expected all 0",
                     rx_byte, rx_word, rx_byte_valid, rx_word_valid, frame_err, busy, miso);
        end
        reset = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_two_bytes();
        tx_status = 8'hA5;
        frame_data[0] = 8'h12;
        frame_data[1] = 8'h34;
        clear_mon();
        send_frame(2, 0);
        checks++;
        if (byte_q.size() != 2) begin
            errors++; $display("FAIL two_bytes_count: got %0d expected 2", byte_q.size());
        end else begin
            checks++;
            if (byte_q[0] !== 8'h12 || byte_q[1] !== 8'h34) begin
                errors++; $display("FAIL two_bytes_data: got %h %h expected 12 34", byte_q[0], byte_q[1]);
            end
        end
        checks++;
        if (word_q.size() != 1) begin
            errors++; $display("FAIL two_bytes_words: got %0d words expected 1", word_q.size());
        end else begin
            checks++;
            if (word_q[0] !== 16'h1234) begin
                errors++; $display("FAIL two_bytes_word: got %h expected 1234", word_q[0]);
            end
        end
        checks++;
        if (ferr_cnt !== 0 || pulse_err !== 0) begin
            errors++; $display("FAIL two_bytes_pulses: got ferr=%0d pulse_err=%0d expected 0 0", ferr_cnt, pulse_err);
        end
        checks++;
        if (miso_seen[0] !== 8'hA5 || miso_seen[1] !== 8'hA5) begin
            errors++; $display("FAIL miso_status: got %h %h expected a5 a5", miso_seen[0], miso_seen[1]);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL two_bytes_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_abort();
        frame_data[0] = 8'h12;
        frame_data[1] = 8'h34;
        clear_mon();
        send_frame(1, 5);
        checks++;
        if (byte_q.size() != 1 || rx_byte !== 8'h12) begin
            errors++; $display("FAIL abort_byte: got count=%0d rx_byte=%h expected 1 12", byte_q.size(), rx_byte);
        end
        checks++;
        if (word_q.size() != 0 || rx_word !== 16'h1234) begin
            errors++; $display("FAIL abort_word: got count=%0d rx_word=%h expected 0 1234", word_q.size(), rx_word);
        end
        checks++;
        if (ferr_cnt !== 1 || pulse_err !== 0) begin
            errors++; $display("FAIL abort_frame_err: got ferr=%0d pulse_err=%0d expected 1 0", ferr_cnt, pulse_err);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL abort_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_four_bytes();
        tx_status = 8'h3C;
        frame_data[0] = 8'hDE;
        frame_data[1] = 8'hAD;
        frame_data[2] = 8'hBE;
        frame_data[3] = 8'hEF;
        clear_mon();
        send_frame(4, 0);
        checks++;
        if (byte_q.size() != 4) begin
            errors++; $display("FAIL four_bytes_count: got %0d expected 4", byte_q.size());
        end else begin
            checks++;
            if (byte_q[0] !== 8'hDE || byte_q[1] !== 8'hAD || byte_q[2] !== 8'hBE || byte_q[3] !== 8'hEF) begin
                errors++; $display("FAIL four_bytes_data: got %h %h %h %h expected de ad be ef",
                                   byte_q[0], byte_q[1], byte_q[2], byte_q[3]);
            end
        end
        checks++;
        if (word_q.size() != 2) begin
            errors++; $display("FAIL four_bytes_words: got %0d words expected 2", word_q.size());
        end else begin
            checks++;
            if (word_q[0] !== 16'hDEAD || word_q[1] !== 16'hBEEF) begin
                errors++; $display("FAIL four_bytes_word: got %h %h expected dead beef", word_q[0], word_q[1]);
            end
        end
        checks++;
        if (ferr_cnt !== 0 || pulse_err !== 0) begin
            errors++; $display("FAIL four_bytes_pulses: got ferr=%0d pulse_err=%0d expected 0 0", ferr_cnt, pulse_err);
        end
        checks++;
        if (miso_seen[0] !== 8'h3C || miso_seen[3] !== 8'h3C) begin
            errors++; $display("FAIL four_bytes_miso: got %h %h expected 3c 3c", miso_seen[0], miso_seen[3]);
        end
    endtask

    task automatic test_idle_sclk();
        int bad;
        bad = 0;
        clear_mon();
        ss_n = 1'b1;
        mosi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sclk = 1'b1;
            repeat (5) begin
                @(negedge clk);
                if (miso !== 1'b0 || busy !== 1'b0) bad++;
            end
            sclk = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (miso !== 1'b0 || busy !== 1'b0) bad++;
            end
        end
        mosi = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (byte_q.size() != 0 || word_q.size() != 0 || ferr_cnt != 0 || bad != 0) begin
            errors++; $display("FAIL idle_sclk: got bytes=%0d words=%0d ferr=%0d miso/busy_bad=%0d expected 0 0 0 0",
                               byte_q.size(), word_q.size(), ferr_cnt, bad);
        end
        frame_data[0] = 8'h00;
        frame_data[1] = 8'hFF;
        clear_mon();
        send_frame(2, 0);
        checks++;
        if (word_q.size() != 1) begin
            errors++; $display("FAIL idle_then_frame_count: got %0d words expected 1", word_q.size());
        end else begin
            checks++;
            if (word_q[0] !== 16'h00FF || rx_byte !== 8'hFF) begin
                errors++; $display("FAIL idle_then_frame_word: got %h byte %h expected 00ff ff", word_q[0], rx_byte);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic m;
        tx_status = 8'hA5;
        frame_data[0] = 8'h12;
        frame_data[1] = 8'h34;
        ss_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 7; i >= 5; i--) sclk_bit(frame_data[0][i], m);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({rx_byte, rx_word, rx_byte_valid, rx_word_valid, frame_err, busy, miso} !== 29'h0) begin
            errors++;
            $display("FAIL async_reset_outputs: got byte=%h word=%h bv=%b wv=%b fe=%b busy=%b miso=%b, expected all 0",
                     rx_byte, rx_word, rx_byte_valid, rx_word_valid, frame_err, busy, miso);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        clear_mon();
        repeat (8) @(negedge clk);
        for (int i = 7; i >= 0; i--) sclk_bit(frame_data[1][i], m);
        repeat (8) @(negedge clk);
        checks++;
        if (byte_q.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL no_frame_after_reset: got bytes=%0d busy=%b expected 0 0", byte_q.size(), busy);
        end
        ss_n = 1'b1;
        repeat (12) @(negedge clk);
        clear_mon();
        send_frame(2, 0);
        checks++;
        if (byte_q.size() != 2 || word_q.size() != 1) begin
            errors++; $display("FAIL post_reset_counts: got bytes=%0d words=%0d expected 2 1", byte_q.size(), word_q.size());
        end else begin
            checks++;
            if (byte_q[0] !== 8'h12 || byte_q[1] !== 8'h34 || word_q[0] !== 16'h1234) begin
                errors++; $display("FAIL post_reset_data: got %h %h word %h expected 12 34 1234",
                                   byte_q[0], byte_q[1], word_q[0]);
            end
        end
        checks++;
        if (ferr_cnt !== 0) begin
            errors++; $display("FAIL post_reset_frame_err: got %0d expected 0", ferr_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_two_bytes();
        test_abort();
        test_four_bytes();
        test_idle_sclk();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
